pwm_bank: RTL and testbench
===========================

Name: pwm_bank

Overview:
- Parametrised multi-channel successor to the single on/off-time PWM register pair in the Bus Pirate top level.
- Sits on the memory-controller register bus, after the WE/OE synchronizers, and drives NUM_CH PWM outputs toward the iobuf pin muxing.
- Adds per-channel enable, polarity, double-buffered (glitch-free) period updates and explicit zero-time handling.
- Write/read strobe edge detection is internal.

Parameters:
- NUM_CH, 4, number of PWM channels (1..8; 2*NUM_CH <= WIDTH).
- WIDTH, 16, counter/register/data width (equals memory-controller data width).
- ADDR_WIDTH, 6, memory-controller address width.
- BASE_ADDR, 6'h18, address of channel 0 on-time register.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- mc_add, in, ADDR_WIDTH: register address.
- mc_din, in, WIDTH: write data.
- mc_we_sync, in, 1: synchronized write-enable level.
- mc_oe_sync, in, 1: synchronized output-enable level.
- rdata, out, WIDTH: registered read data.
- hit, out, 1: combinational, 1 when mc_add is inside this block's map (for the top-level read mux).
- pwm_out, out, NUM_CH: PWM outputs.

Behaviour:
Register map, offset from BASE_ADDR:
- 2k: channel k on-time staging (ON_k).
- 2k+1: channel k off-time staging (OFF_k).
- 2*NUM_CH: CTRL. Bits [NUM_CH-1:0] enable; bits [2*NUM_CH-1:NUM_CH] polarity; remaining bits read 0.
- 2*NUM_CH+1: STATUS, read-only. Bits [NUM_CH-1:0] current phase (1 = ON); bits [2*NUM_CH-1:NUM_CH] reload pending.
- Addresses outside the map: hit=0, writes ignored, rdata unchanged.

Bus handshake:
- Rising edges of mc_we_sync and mc_oe_sync are detected with one registered copy of each.
- A write commits on the clock edge after the rising edge is detected.
- On a read edge, rdata is loaded on the same edge, so it is valid one cycle after detection and holds until the next read.
- Simultaneous WE and OE rising edges: write wins, read ignored.
- Writes to STATUS are ignored.

Reset (reset=0, asynchronous):
- All staging, active and CTRL registers = 0.
- Counters = 0; phase = OFF; pending = 0.
- rdata = 0; pwm_out = 0.

Channel k, per-channel FSM with states IDLE, ON, OFF:
- IDLE (enable=0): pwm_out[k] = polarity[k]; counter held at 0; staging copies to active every cycle; pending = 0.
- Enable 0->1: load active from staging, counter=0, go to ON (or to OFF if active_on=0). First output cycle is the cycle after the CTRL write commits.
- ON: pwm_out[k] = ~polarity[k]. Counter increments. When counter == active_on-1: counter=0, go to OFF; if active_off=0, apply the reload rule instead and stay in ON.
- OFF: pwm_out[k] = polarity[k]. When counter == active_off-1: reload rule.
- Reload rule: copy staging to active, clear pending, counter=0. Next state is ON if the new on>0, otherwise OFF.
- Both active values 0: channel holds OFF at idle level; it re-evaluates staging every cycle.
- Period = on+off cycles. Duty = on/(on+off). on=0 gives constant idle level; off=0 gives constant active level.
- Writing ON_k/OFF_k while enabled sets pending[k]; active values change only at the period boundary, so no runt pulses.
- Disable 1->0: output goes to idle level on the next cycle; counter is cleared.
- Polarity changes take effect immediately.
- Counters are WIDTH bits and never wrap: the maximum count is 2^WIDTH-2 (compare at value-1).

Decomposition:
- Package pwm_bank_pkg holds:
  - register offset constants (OFS_CTRL, OFS_STATUS as functions of NUM_CH);
  - the channel state enum {IDLE, ON, OFF};
  - the edge-detect helper.
- Sub-module pwm_channel (WIDTH param) owns the staging/active registers, counter, FSM and pending flag.
- pwm_bank owns address decode, edge detection, CTRL, rdata, and the NUM_CH generate loop.

Test Plan:
- Reset release, then no writes -> pwm_out=0, rdata=0; STATUS read (addr 6'h21) returns 0x0000.
- Write ON_0=3, OFF_0=5, CTRL=0x0001 -> pwm_out[0] repeats 3 cycles high, 5 low (period 8); other channels stay 0.
- Channel 0 running 3/5; write ON_0=6 mid-ON -> STATUS bit4=1; current period stays 3/5; next period 6/5; pending clears at the boundary.
- CTRL=0x0011 with ON_0=0, OFF_0=4 -> pwm_out[0] constant 1 (idle level, inverted polarity). Then OFF_0=0, ON_0=4 -> constant 0 after the boundary.
- Assert reset low mid-ON, asynchronously, with channels 0–3 enabled -> pwm_out=0 immediately, CTRL reads 0 after release, channels idle.
- WE and OE rising in the same cycle at ON_1 with din=0x0042 -> ON_1=0x0042, rdata unchanged. A later read of 6'h1a returns 0x0042; a read of 6'h30 gives hit=0 and rdata unchanged.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the PWM bank: register offsets, channel states
// and the strobe edge-detect helper.
package pwm_bank_pkg;

   // Channel sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } ch_state_t;

   // CTRL sits directly after the per-channel ON/OFF register pairs
   function automatic int ofs_ctrl(input int num_ch);
      return 2 * num_ch;
   endfunction

   // STATUS follows CTRL
   function automatic int ofs_status(input int num_ch);
      return 2 * num_ch + 1;
   endfunction

   // Rising-edge detect against a one-cycle-delayed copy of the level
   function automatic logic rise(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: staging and active on/off times, period counter,
// IDLE/ON/OFF sequencer and the reload-pending flag.
module pwm_channel
   import pwm_bank_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_on,
   input  logic             wr_off,
   input  logic [WIDTH-1:0] din,
   input  logic             enable,
   input  logic             polarity,
   output logic [WIDTH-1:0] staging_on,
   output logic [WIDTH-1:0] staging_off,
   output logic             pwm,
   output logic             phase_on,
   output logic             pending
);

   ch_state_t        state;
   ch_state_t        state_next;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] act_on;
   logic [WIDTH-1:0] act_on_next;
   logic [WIDTH-1:0] act_off;
   logic [WIDTH-1:0] act_off_next;
   logic             pending_next;
   logic             reload;

   // Bus writes land in the staging registers only
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         staging_on  <= '0;
         staging_off <= '0;
      end else begin
         if (wr_on)  staging_on  <= din;
         if (wr_off) staging_off <= din;
      end
   end

   // Sequencer state, counter, active times and pending flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         count   <= '0;
         act_on  <= '0;
         act_off <= '0;
         pending <= 1'b0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         act_on  <= act_on_next;
         act_off <= act_off_next;
         pending <= pending_next;
      end
   end

   // Next-state logic; a reload always happens at a period boundary so
   // the active times never change mid-pulse
   always_comb begin
      state_next   = state;
      count_next   = count;
      act_on_next  = act_on;
      act_off_next = act_off;
      pending_next = pending;
      reload       = 1'b0;

      case (state)
         IDLE: begin
            act_on_next  = staging_on;
            act_off_next = staging_off;
            count_next   = '0;
            pending_next = 1'b0;
            if (enable) begin
               state_next = (staging_on != '0) ? ON : OFF;
            end
         end
         ON: begin
            if (!enable) begin
               state_next   = IDLE;
               count_next   = '0;
               pending_next = 1'b0;
            end else if (count == act_on - 1'b1) begin
               if (act_off == '0) begin
                  reload = 1'b1;
               end else begin
                  count_next = '0;
                  state_next = OFF;
               end
            end else begin
               count_next = count + 1'b1;
            end
         end
         OFF: begin
            if (!enable) begin
               state_next   = IDLE;
               count_next   = '0;
               pending_next = 1'b0;
            end else if ((act_off == '0) || (count == act_off - 1'b1)) begin
               reload = 1'b1;
            end else begin
               count_next = count + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase

      if (reload) begin
         act_on_next  = staging_on;
         act_off_next = staging_off;
         count_next   = '0;
         pending_next = 1'b0;
         state_next   = (staging_on != '0) ? ON : OFF;
      end

      if ((state != IDLE) && enable && (wr_on || wr_off)) begin
         pending_next = 1'b1;
      end
   end

   assign phase_on = (state == ON);
   assign pwm      = phase_on ^ polarity;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM register block on the memory-controller bus:
// address decode, strobe edge detect, CTRL, read-back and channel array.
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter int                    NUM_CH     = 4,
   parameter int                    WIDTH      = 16,
   parameter int                    ADDR_WIDTH = 6,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 6'h18
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] mc_add,
   input  logic [WIDTH-1:0]      mc_din,
   input  logic                  mc_we_sync,
   input  logic                  mc_oe_sync,
   output logic [WIDTH-1:0]      rdata,
   output logic                  hit,
   output logic [NUM_CH-1:0]     pwm_out
);

   localparam logic [ADDR_WIDTH-1:0] OFS_CTRL   = ADDR_WIDTH'(ofs_ctrl(NUM_CH));
   localparam logic [ADDR_WIDTH-1:0] OFS_STATUS = ADDR_WIDTH'(ofs_status(NUM_CH));

   logic [ADDR_WIDTH-1:0] ofs;
   logic                  we_q;
   logic                  oe_q;
   logic                  we_rise;
   logic                  wr;
   logic                  rd;
   logic [2*NUM_CH-1:0]   ctrl;
   logic [2*NUM_CH-1:0]   ctrl_next;
   logic [WIDTH-1:0]      stg_on  [NUM_CH];
   logic [WIDTH-1:0]      stg_off [NUM_CH];
   logic [NUM_CH-1:0]     phase;
   logic [NUM_CH-1:0]     pend;
   logic [WIDTH-1:0]      rd_val;

   assign ofs     = mc_add - BASE_ADDR;
   assign hit     = (mc_add >= BASE_ADDR) && (ofs <= OFS_STATUS);
   assign we_rise = rise(mc_we_sync, we_q);
   assign wr      = we_rise & hit;
   assign rd      = rise(mc_oe_sync, oe_q) & ~we_rise & hit;

   // Delayed strobe copies for edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         we_q <= 1'b0;
         oe_q <= 1'b0;
      end else begin
         we_q <= mc_we_sync;
         oe_q <= mc_oe_sync;
      end
   end

   // Channels see the post-write enable so they start or stop on the
   // same edge that commits the CTRL write
   assign ctrl_next = (wr && (ofs == OFS_CTRL)) ? mc_din[2*NUM_CH-1:0] : ctrl;

   // CTRL register: enables in the low half, polarities in the high half
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl <= '0;
      end else begin
         ctrl <= ctrl_next;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      pwm_channel #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clock      (clock),
         .reset      (reset),
         .wr_on      (wr && (ofs == ADDR_WIDTH'(2 * k))),
         .wr_off     (wr && (ofs == ADDR_WIDTH'(2 * k + 1))),
         .din        (mc_din),
         .enable     (ctrl_next[k]),
         .polarity   (ctrl[NUM_CH + k]),
         .staging_on (stg_on[k]),
         .staging_off(stg_off[k]),
         .pwm        (pwm_out[k]),
         .phase_on   (phase[k]),
         .pending    (pend[k])
      );
   end

   // Read-back multiplexer over the register map
   always_comb begin
      rd_val = '0;
      if (ofs == OFS_CTRL) begin
         rd_val[2*NUM_CH-1:0] = ctrl;
      end else if (ofs == OFS_STATUS) begin
         rd_val[NUM_CH-1:0]        = phase;
         rd_val[2*NUM_CH-1:NUM_CH] = pend;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ofs == ADDR_WIDTH'(2 * k))     rd_val = stg_on[k];
            if (ofs == ADDR_WIDTH'(2 * k + 1)) rd_val = stg_off[k];
         end
      end
   end

   // Read data is captured on a read edge and held until the next one
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (rd) begin
         rdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: a period-position reference model pushes
// expected outputs every cycle, a monitor pops and compares them.
module tb_pwm_bank;

   localparam int NC = 4;

   typedef struct {
      logic [NC-1:0] pwm;
      logic [15:0]   rdata;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  mc_add = '0;
   logic [15:0] mc_din = '0;
   logic        mc_we_sync = 1'b0;
   logic        mc_oe_sync = 1'b0;
   logic [15:0] rdata;
   logic        hit;
   logic [NC-1:0] pwm_out;

   int checks = 0;
   int errors = 0;

   bit issue_wr = 1'b0;
   bit issue_rd = 1'b0;

   exp_t exp_q[$];

   int          m_stg_on [NC];
   int          m_stg_off[NC];
   int          m_act_on [NC];
   int          m_act_off[NC];
   int          m_pos    [NC];
   bit          m_run    [NC];
   bit          m_pend   [NC];
   int          m_ctrl  = 0;
   logic [15:0] m_rdata = '0;

   pwm_bank #(
      .NUM_CH    (NC),
      .WIDTH     (16),
      .ADDR_WIDTH(6),
      .BASE_ADDR (6'h18)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .mc_add    (mc_add),
      .mc_din    (mc_din),
      .mc_we_sync(mc_we_sync),
      .mc_oe_sync(mc_oe_sync),
      .rdata     (rdata),
      .hit       (hit),
      .pwm_out   (pwm_out)
   );

   always #5 clock = ~clock;

   function automatic bit in_map(input int a);
      return (a >= 24) && (a <= 24 + 2 * NC + 1);
   endfunction

   function automatic bit model_phase(input int ch);
      return m_run[ch] && (m_pos[ch] < m_act_on[ch]);
   endfunction

   function automatic logic [15:0] model_read(input int o);
      int v;
      v = 0;
      if (o < 2 * NC) begin
         v = (o % 2 == 0) ? m_stg_on[o / 2] : m_stg_off[o / 2];
      end else if (o == 2 * NC) begin
         v = m_ctrl;
      end else begin
         for (int c = 0; c < NC; c++) begin
            if (model_phase(c)) v = v | (1 << c);
            if (m_pend[c])      v = v | (1 << (NC + c));
         end
      end
      return 16'(v);
   endfunction

   function automatic logic [NC-1:0] model_pwm();
      logic [NC-1:0] p;
      for (int c = 0; c < NC; c++) begin
         p[c] = model_phase(c) ^ ((m_ctrl >> (NC + c)) & 1);
      end
      return p;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         m_stg_on[c] = 0; m_stg_off[c] = 0; m_act_on[c] = 0; m_act_off[c] = 0;
         m_pos[c] = 0; m_run[c] = 1'b0; m_pend[c] = 1'b0;
      end
      m_ctrl  = 0;
      m_rdata = '0;
      exp_q.delete();
   endtask

   // Reference model: each channel is a position within a period of
   // on+off cycles, output active while position < on
   initial begin
      model_reset();
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            model_reset();
         end else begin
            int o, new_ctrl, wch, per;
            bit won, en;
            ex: o = int'(mc_add) - 24;
            new_ctrl = m_ctrl;
            wch = -1;
            won = 1'b0;
            if (issue_rd && !issue_wr && in_map(int'(mc_add))) m_rdata = model_read(o);
            if (issue_wr && in_map(int'(mc_add))) begin
               if (o == 2 * NC) new_ctrl = int'(mc_din) & ((1 << (2 * NC)) - 1);
               else if (o < 2 * NC) begin
                  wch = o / 2;
                  won = (o % 2 == 0);
               end
            end
            for (int c = 0; c < NC; c++) begin
               en = ((new_ctrl >> c) & 1) != 0;
               if (!en) begin
                  m_run[c] = 1'b0; m_pend[c] = 1'b0; m_pos[c] = 0;
                  m_act_on[c] = m_stg_on[c]; m_act_off[c] = m_stg_off[c];
               end else if (!m_run[c]) begin
                  m_run[c] = 1'b1; m_pos[c] = 0;
                  m_act_on[c] = m_stg_on[c]; m_act_off[c] = m_stg_off[c];
               end else begin
                  per = m_act_on[c] + m_act_off[c];
                  if (per == 0) per = 1;
                  if (m_pos[c] == per - 1) begin
                     m_act_on[c] = m_stg_on[c]; m_act_off[c] = m_stg_off[c];
                     m_pos[c] = 0; m_pend[c] = 1'b0;
                  end else begin
                     m_pos[c] = m_pos[c] + 1;
                  end
                  if (wch == c) m_pend[c] = 1'b1;
               end
            end
            if (wch >= 0) begin
               if (won) m_stg_on[wch]  = int'(mc_din);
               else     m_stg_off[wch] = int'(mc_din);
            end
            m_ctrl = new_ctrl;
            exp_q.push_back('{pwm: model_pwm(), rdata: m_rdata});
         end
      end
   end

   task automatic check_output(input exp_t e);
      checks++;
      if (pwm_out !== e.pwm) begin
         errors++;
         $display("[TB] FAIL pwm_out at %0t: got %b expected %b", $time, pwm_out, e.pwm);
      end
      checks++;
      if (rdata !== e.rdata) begin
         errors++;
         $display("[TB] FAIL rdata at %0t: got %h expected %h", $time, rdata, e.rdata);
      end
      checks++;
      if (hit !== in_map(int'(mc_add))) begin
         errors++;
         $display("[TB] FAIL hit addr %h at %0t: got %b expected %b", mc_add, $time, hit, in_map(int'(mc_add)));
      end
   endtask

   // Monitor: compare the DUT against the oldest expected entry
   initial begin
      forever begin
         @(negedge clock);
         if (reset && exp_q.size() > 0) check_output(exp_q.pop_front());
      end
   end

   // One bus transaction: strobes high for a cycle, then low for a cycle
   task automatic apply_stimulus(input logic [5:0] a, input logic [15:0] d, input bit w, input bit r);
      mc_add = a; mc_din = d; mc_we_sync = w; mc_oe_sync = r;
      issue_wr = w; issue_rd = r;
      @(posedge clock); #1;
      issue_wr = 1'b0; issue_rd = 1'b0; mc_we_sync = 1'b0; mc_oe_sync = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      idle(4);
      apply_stimulus(6'h21, 16'h0000, 1'b0, 1'b1);
      idle(2);

      // 3 on / 5 off on channel 0
      apply_stimulus(6'h18, 16'd3, 1'b1, 1'b0);
      apply_stimulus(6'h19, 16'd5, 1'b1, 1'b0);
      apply_stimulus(6'h20, 16'h0001, 1'b1, 1'b0);
      idle(21);

      // staged update while running, observe pending then the boundary
      apply_stimulus(6'h18, 16'd6, 1'b1, 1'b0);
      apply_stimulus(6'h21, 16'h0000, 1'b0, 1'b1);
      idle(24);
      apply_stimulus(6'h21, 16'h0000, 1'b0, 1'b1);

      // zero on-time with inverted polarity, then zero off-time
      apply_stimulus(6'h20, 16'h0000, 1'b1, 1'b0);
      apply_stimulus(6'h18, 16'd0, 1'b1, 1'b0);
      apply_stimulus(6'h19, 16'd4, 1'b1, 1'b0);
      apply_stimulus(6'h20, 16'h0011, 1'b1, 1'b0);
      idle(12);
      apply_stimulus(6'h19, 16'd0, 1'b1, 1'b0);
      idle(6);
      apply_stimulus(6'h18, 16'd4, 1'b1, 1'b0);
      idle(14);

      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 3)
            apply_stimulus(6'(24 + $urandom_range(0, 2 * NC - 1)), 16'($urandom_range(0, 6)), 1'b1, 1'b0);
         else if (op == 4)
            apply_stimulus(6'h20, 16'($urandom_range(0, 255)), 1'b1, 1'b0);
         else if (op <= 6)
            apply_stimulus(6'($urandom_range(16, 40)), 16'h0000, 1'b0, 1'b1);
         else if (op == 7)
            apply_stimulus(6'($urandom_range(22, 36)), 16'($urandom_range(0, 6)), 1'b1, 1'b1);
         else
            idle($urandom_range(1, 12));
      end
      idle(20);

      // asynchronous reset while all channels are in their ON phase
      for (int c = 0; c < NC; c++) begin
         apply_stimulus(6'(24 + 2 * c), 16'd5, 1'b1, 1'b0);
         apply_stimulus(6'(25 + 2 * c), 16'd3, 1'b1, 1'b0);
      end
      apply_stimulus(6'h20, 16'h000F, 1'b1, 1'b0);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (pwm_out !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset_pwm: got %b expected 0000", pwm_out);
      end
      checks++;
      if (rdata !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset_rdata: got %h expected 0000", rdata);
      end
      idle(2);
      reset = 1'b1;
      idle(2);
      apply_stimulus(6'h20, 16'h0000, 1'b0, 1'b1);
      idle(4);

      // simultaneous strobes: write wins, read dropped
      apply_stimulus(6'h1a, 16'h0042, 1'b1, 1'b1);
      idle(2);
      apply_stimulus(6'h1a, 16'h0000, 1'b0, 1'b1);
      apply_stimulus(6'h30, 16'h0000, 1'b0, 1'b1);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
